// File: rtl/uart_pwm_pkg.sv
// uart_pwm_pkg: shared state encoding and ASCII constants for the duty status reporter
package uart_pwm_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, SEND} state_t;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int FRAME_LEN = 7;
endpackage

// File: rtl/dec3_converter.sv
// dec3_converter: binary to three ASCII decimal digits by repeated subtraction, one step per cycle
import uart_pwm_pkg::*;
module dec3_converter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] value,
  output logic         done,
  output logic [7:0]   hund,
  output logic [7:0]   tens,
  output logic [7:0]   ones
);
  localparam logic [W-1:0] C100 = W'(100);
  localparam logic [W-1:0] C10 = W'(10);
  logic [W-1:0] rem;
  logic [3:0] h, t;
  logic active;
  // load on start, then peel off hundreds before tens until only the ones digit is left
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      h <= '0;
      t <= '0;
      active <= 1'b0;
    end else if (start) begin
      rem <= value;
      h <= '0;
      t <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (rem >= C100) begin
        rem <= rem - C100;
        h <= h + 4'd1;
      end else if (rem >= C10) begin
        rem <= rem - C10;
        t <= t + 4'd1;
      end else active <= 1'b0;
    end
  assign done = active && rem < C10;
  assign hund = ASCII_ZERO + {4'b0, h};
  assign tens = ASCII_ZERO + {4'b0, t};
  assign ones = ASCII_ZERO + 8'(rem);
endmodule

// File: rtl/duty_status_reporter.sv
// duty_status_reporter: sends "D=nnn\r\n" over valid/ready on request; AUTO_REPORT_EN adds change-triggered frames
import uart_pwm_pkg::*;
module duty_status_reporter #(
  parameter int          DUTY_W = 7,
  parameter int          MAX_DUTY = 100,
  parameter logic [7:0]  TAG_CHAR = 8'h44
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty_cycle,
  input  logic              report_req,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);
  localparam logic [DUTY_W-1:0] MAX_V = DUTY_W'(MAX_DUTY);
  state_t state, state_n;
  logic [2:0] idx;
  logic pending, req_any, start, last, done;
  logic [DUTY_W-1:0] sat;
  logic [7:0] hund, tens, ones;
  assign sat = duty_cycle > MAX_V ? MAX_V : duty_cycle;
`ifdef AUTO_REPORT_EN
  logic [DUTY_W-1:0] last_sent;
  // remember the value of the most recently started frame so a settled change retriggers once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_sent <= '0;
    else if (start) last_sent <= sat;
  assign req_any = report_req || sat != last_sent;
`else
  assign req_any = report_req;
`endif
  assign last = state == SEND && tx_ready && idx == 3'(FRAME_LEN - 1);
  assign start = state_n == CONVERT && state != CONVERT;
  dec3_converter #(.W(DUTY_W)) u_conv (
    .clk(clk), .rst_n(rst_n), .start(start), .value(sat),
    .done(done), .hund(hund), .tens(tens), .ones(ones)
  );
  // state, byte index and the single coalescing pending slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      pending <= 1'b0;
    end else begin
      state <= state_n;
      idx <= state != SEND ? 3'd0 : idx + 3'(tx_ready);
      pending <= start ? 1'b0 : pending || (state != IDLE && req_any);
    end
  // a request arriving with the last byte chains straight into the next conversion
  always_comb
    state_n = state == IDLE ? (req_any ? CONVERT : IDLE) :
              state == CONVERT ? (done ? SEND : CONVERT) :
              last ? (pending || req_any ? CONVERT : IDLE) : SEND;
  // frame byte mux; idle output is zero
  always_comb begin
    tx_valid = state == SEND;
    busy = state != IDLE;
    tx_data = !tx_valid ? 8'h00 :
              idx == 3'd0 ? TAG_CHAR :
              idx == 3'd1 ? ASCII_EQ :
              idx == 3'd2 ? hund :
              idx == 3'd3 ? tens :
              idx == 3'd4 ? ones :
              idx == 3'd5 ? ASCII_CR : ASCII_LF;
  end
endmodule
